// File: rtl/test_pattern_gen.sv
// test_pattern_gen: selectable VGA test-pattern source with frame-aligned mode
// switching, a bouncing box animated once per frame, and a frame counter.
// Output channels are registered, giving one cycle of latency from xPos/yPos.
module test_pattern_gen #(
  parameter int COLOR_W     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int CHECK_SHIFT = 5,
  parameter int BOX_SIZE    = 32
) (
  input  logic                   vga_clk,
  input  logic                   RST,
  input  logic [9:0]             xPos,
  input  logic [9:0]             yPos,
  input  logic                   video_on,
  input  logic                   frame_start,
  input  logic [2:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_color,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic [7:0]             frame_cnt
);

  localparam logic [COLOR_W-1:0] MAX_LVL   = '1;
  localparam int                 BAR_W     = H_ACTIVE / 8;
  localparam int                 STEP      = H_ACTIVE >> COLOR_W;
  localparam logic [9:0]         STEP_LAST = 10'(STEP - 1);
  localparam logic [9:0]         MAXX      = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]         MAXY      = 10'(V_ACTIVE - BOX_SIZE);

  typedef enum logic [2:0] {
    M_WHITE    = 3'd0,
    M_SOLID    = 3'd1,
    M_BARS     = 3'd2,
    M_CHECKER  = 3'd3,
    M_GRADIENT = 3'd4,
    M_BOX      = 3'd5
  } pattern_e;

  logic [2:0]          active_mode;
  logic [9:0]          box_x, box_y;
  logic                dx_pos, dy_pos;
  logic [COLOR_W-1:0]  grad_lvl_q, grad_lvl_nxt;
  logic [9:0]          grad_sub_q, grad_sub_nxt;
  logic [2:0]          bar_idx;
  logic                in_box;
  logic [COLOR_W-1:0]  pix_r, pix_g, pix_b;

  // Frame-boundary state: mode latch, frame counter and the box animation.
  // The box only moves while the frame that just ended was showing it.
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) begin
      active_mode <= 3'd0;
      frame_cnt   <= 8'd0;
      box_x       <= 10'd0;
      box_y       <= 10'd0;
      dx_pos      <= 1'b1;
      dy_pos      <= 1'b1;
    end else if (frame_start) begin
      active_mode <= mode;
      frame_cnt   <= frame_cnt + 8'd1;
      if (active_mode == M_BOX) begin
        if (dx_pos) begin
          if (box_x == MAXX) begin
            dx_pos <= 1'b0;
            box_x  <= MAXX - 10'd1;
          end else begin
            box_x  <= box_x + 10'd1;
          end
        end else begin
          if (box_x == 10'd0) begin
            dx_pos <= 1'b1;
            box_x  <= 10'd1;
          end else begin
            box_x  <= box_x - 10'd1;
          end
        end
        if (dy_pos) begin
          if (box_y == MAXY) begin
            dy_pos <= 1'b0;
            box_y  <= MAXY - 10'd1;
          end else begin
            box_y  <= box_y + 10'd1;
          end
        end else begin
          if (box_y == 10'd0) begin
            dy_pos <= 1'b1;
            box_y  <= 10'd1;
          end else begin
            box_y  <= box_y - 10'd1;
          end
        end
      end
    end
  end

  // Gradient level for the current pixel, derived from the previous pixel's
  // level so that no divider is needed; the scan restarts at xPos == 0.
  always_comb begin
    grad_sub_nxt = grad_sub_q;
    grad_lvl_nxt = grad_lvl_q;
    if (xPos == 10'd0) begin
      grad_sub_nxt = 10'd0;
      grad_lvl_nxt = '0;
    end else if (grad_sub_q == STEP_LAST) begin
      grad_sub_nxt = 10'd0;
      grad_lvl_nxt = (grad_lvl_q == MAX_LVL) ? MAX_LVL : grad_lvl_q + 1'b1;
    end else begin
      grad_sub_nxt = grad_sub_q + 10'd1;
    end
  end

  // Remember the gradient step position of the pixel just presented.
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) begin
      grad_sub_q <= 10'd0;
      grad_lvl_q <= '0;
    end else begin
      grad_sub_q <= grad_sub_nxt;
      grad_lvl_q <= grad_lvl_nxt;
    end
  end

  // Colour-bar index as a count of bar boundaries already passed.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xPos >= 10'(k * BAR_W)) bar_idx = bar_idx + 3'd1;
    end
  end

  // Box hit test against the current box position.
  always_comb begin
    in_box = ({1'b0, xPos} >= {1'b0, box_x}) &&
             ({1'b0, xPos} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
             ({1'b0, yPos} >= {1'b0, box_y}) &&
             ({1'b0, yPos} <  {1'b0, box_y} + 11'(BOX_SIZE));
  end

  // Pattern selection for the current pixel.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (active_mode)
      M_WHITE: begin
        pix_r = MAX_LVL;
        pix_g = MAX_LVL;
        pix_b = MAX_LVL;
      end
      M_SOLID: begin
        pix_r = solid_color[3*COLOR_W-1:2*COLOR_W];
        pix_g = solid_color[2*COLOR_W-1:COLOR_W];
        pix_b = solid_color[COLOR_W-1:0];
      end
      M_BARS: begin
        pix_r = {COLOR_W{~bar_idx[1]}};
        pix_g = {COLOR_W{~bar_idx[2]}};
        pix_b = {COLOR_W{~bar_idx[0]}};
      end
      M_CHECKER: begin
        pix_r = {COLOR_W{~(xPos[CHECK_SHIFT] ^ yPos[CHECK_SHIFT])}};
        pix_g = pix_r;
        pix_b = pix_r;
      end
      M_GRADIENT: begin
        pix_r = grad_lvl_nxt;
        pix_g = grad_lvl_nxt;
        pix_b = grad_lvl_nxt;
      end
      M_BOX: begin
        if (in_box) begin
          pix_r = solid_color[3*COLOR_W-1:2*COLOR_W];
          pix_g = solid_color[2*COLOR_W-1:COLOR_W];
          pix_b = solid_color[COLOR_W-1:0];
        end
      end
      default: begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
      end
    endcase
  end

  // Output register; blanking forces black regardless of pattern.
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (!video_on) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= pix_r;
      green <= pix_g;
      blue  <= pix_b;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// tb_test_pattern_gen: directed and randomised checks of test_pattern_gen
// against an arithmetic pixel model (division, min, triangle-wave box).
module tb_test_pattern_gen;

  localparam int CW    = 4;
  localparam int MAXX  = 640 - 32;
  localparam int MAXY  = 480 - 32;

  logic        vga_clk = 1'b0;
  logic        RST = 1'b0;
  logic [9:0]  xPos = '0;
  logic [9:0]  yPos = '0;
  logic        video_on = 1'b0;
  logic        frame_start = 1'b0;
  logic [2:0]  mode = '0;
  logic [11:0] solid_color = '0;
  logic [3:0]  red, green, blue;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int fails  = 0;

  int model_mode   = 0;
  int model_steps  = 0;
  int model_frames = 0;

  test_pattern_gen dut (
    .vga_clk     (vga_clk),
    .RST         (RST),
    .xPos        (xPos),
    .yPos        (yPos),
    .video_on    (video_on),
    .frame_start (frame_start),
    .mode        (mode),
    .solid_color (solid_color),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_cnt   (frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  // Position of a bouncing coordinate after n steps: a triangle wave 0..maxv.
  function automatic int triPos(input int n, input int maxv);
    int p;
    p = n % (2 * maxv);
    return (p <= maxv) ? p : 2 * maxv - p;
  endfunction

  function automatic int boxX();
    return triPos(model_steps, MAXX);
  endfunction

  function automatic int boxY();
    return triPos(model_steps, MAXY);
  endfunction

  // Expected {R,G,B} for a pixel, computed from the pattern definitions.
  function automatic logic [11:0] expPixel(input int x, input int y, input bit von,
                                           input int m, input logic [11:0] sc);
    int bar, g, bx, by;
    if (!von) return 12'h000;
    case (m)
      0: return 12'hFFF;
      1: return sc;
      2: begin
        bar = x / 80;
        case (bar)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      3: return ((((x / 32) + (y / 32)) % 2) == 0) ? 12'hFFF : 12'h000;
      4: begin
        g = x / 40;
        if (g > 15) g = 15;
        return {g[3:0], g[3:0], g[3:0]};
      end
      5: begin
        bx = boxX();
        by = boxY();
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return sc;
        return 12'h000;
      end
      default: return 12'h000;
    endcase
  endfunction

  // Present one pixel and let it pass the output register.
  task automatic applyStimulus(input int x, input int y, input bit von);
    xPos     = 10'(x);
    yPos     = 10'(y);
    video_on = von;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] expected);
    logic [11:0] observed;
    observed = {red, green, blue};
    checks++;
    assert (observed === expected)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic checkCount(input string tag, input int expected);
    checks++;
    assert (frame_cnt === 8'(expected))
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", tag, frame_cnt, expected % 256);
      end
  endtask

  task automatic checkPixel(input string tag, input int x, input int y, input bit von);
    applyStimulus(x, y, von);
    checkOutput(tag, expPixel(x, y, von, model_mode, solid_color));
  endtask

  // One frame boundary during blanking; the model follows the same rules.
  task automatic pulseFrame(input int m);
    frame_start = 1'b1;
    video_on    = 1'b0;
    mode        = 3'(m);
    @(posedge vga_clk);
    #1;
    frame_start = 1'b0;
    if (model_mode == 5) model_steps++;
    model_mode   = m;
    model_frames = model_frames + 1;
  endtask

  task automatic sweepGradient(input int last_x, input int y);
    for (int x = 0; x <= last_x; x++) checkPixel("gradient", x, y, 1'b1);
  endtask

  task automatic randomPixels(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      solid_color = 12'($urandom);
      checkPixel(tag, $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    int m, bx, by;
    int bars_x[16] = '{0, 79, 80, 159, 160, 239, 240, 319, 320, 399, 400, 479, 480, 559, 560, 639};

    // Reset state, held with the clock running.
    repeat (3) @(posedge vga_clk);
    #1;
    checkOutput("reset_rgb", 12'h000);
    checkCount("reset_cnt", 0);
    @(negedge vga_clk);
    RST = 1'b1;

    // Mode 0 after reset without any frame_start.
    checkPixel("white_on", 100, 50, 1'b1);
    checkOutput("white_on_exact", 12'hFFF);
    checkPixel("white_off", 100, 50, 1'b0);
    randomPixels("white_rand", 10);

    // Colour bars at every boundary plus random pixels.
    pulseFrame(2);
    checkCount("cnt_after_1", 1);
    for (int i = 0; i < 16; i++) checkPixel("bars_edge", bars_x[i], 10, 1'b1);
    randomPixels("bars_rand", 20);

    // Checkerboard corners and random pixels.
    pulseFrame(3);
    checkPixel("check_31_0", 31, 0, 1'b1);
    checkPixel("check_32_0", 32, 0, 1'b1);
    checkPixel("check_32_32", 32, 32, 1'b1);
    randomPixels("check_rand", 20);

    // Gradient needs a contiguous scan starting at x = 0.
    pulseFrame(4);
    sweepGradient(639, 7);
    sweepGradient(120, 8);

    // Solid colour follows the live input.
    pulseFrame(1);
    randomPixels("solid_rand", 15);

    // Reserved modes.
    pulseFrame(6);
    randomPixels("mode6_rand", 8);
    pulseFrame(7);
    randomPixels("mode7_rand", 8);

    // Bouncing box across both reversals, checked along the way.
    solid_color = 12'hF00;
    pulseFrame(5);
    for (int f = 1; f <= 700; f++) begin
      pulseFrame(5);
      if (f % 25 == 0 || (f >= 606 && f <= 611)) begin
        bx = boxX();
        by = boxY();
        checkPixel("box_in", bx, by, 1'b1);
        checkPixel("box_right", bx + 32, by, 1'b1);
        checkPixel("box_corner", bx + 31, by + 31, 1'b1);
        if (bx > 0) checkPixel("box_left", bx - 1, by, 1'b1);
      end
    end
    checkCount("cnt_box", model_frames);
    bx = boxX();
    by = boxY();
    checkPixel("box_final_in", bx, by, 1'b1);
    checkOutput("box_final_red", 12'hF00);

    // Mode request changes without frame_start: box stays on screen.
    mode = 3'd1;
    checkPixel("hold_outside", bx + 40, by, 1'b1);
    checkOutput("hold_outside_black", 12'h000);
    checkPixel("hold_inside", bx + 5, by + 5, 1'b1);

    // Random frame sequence with random pixels in whatever mode is active.
    for (int i = 0; i < 25; i++) begin
      m = $urandom_range(0, 7);
      pulseFrame(m);
      if (m == 4) begin
        sweepGradient(90, 3);
      end else if (m == 5) begin
        for (int j = 0; j < 6; j++) begin
          solid_color = 12'($urandom);
          checkPixel("rand_box", boxX() + $urandom_range(0, 40) - 4,
                     boxY() + $urandom_range(0, 40) - 4, 1'b1);
        end
      end else begin
        randomPixels("rand_frame", 6);
      end
    end
    checkCount("cnt_rand", model_frames);

    // Asynchronous reset in the middle of a visible line.
    solid_color = 12'h0F0;
    pulseFrame(1);
    checkPixel("pre_reset", 200, 100, 1'b1);
    xPos = 10'd201;
    #3;
    RST = 1'b0;
    #1;
    checkOutput("async_rgb", 12'h000);
    checkCount("async_cnt", 0);
    @(negedge vga_clk);
    RST = 1'b1;
    model_mode   = 0;
    model_steps  = 0;
    model_frames = 0;
    mode = 3'd3;
    checkPixel("post_reset_white", 202, 100, 1'b1);
    checkCount("post_reset_cnt", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
